mem_copy_engine: RTL

- Bus initiator for the single-port 1024x16 data memory. It drives that memory's adr, mem_read, mem_write and write_data, and consumes its out.
- Performs block copy: len words from src_adr to dst_adr, in ascending order, one word at a time.
- Produces a 16-bit additive checksum of the words copied.
- Sits beside the pipeline's MEM stage; the pipeline owns the memory bus while busy is low.

---
 rtl/mem_copy_if.sv | 30 +++
 rtl/mem_copy_engine.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mem_copy_if.sv
// Bus bundle between the copy engine and its host: request/status signals
// plus the single-port data-memory initiator signals.
interface mem_copy_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 16,
   parameter int LEN_W  = 11
);
   logic              start;
   logic [ADDR_W-1:0] src_adr;
   logic [ADDR_W-1:0] dst_adr;
   logic [LEN_W-1:0]  len;
   logic              busy;
   logic              done;
   logic [DATA_W-1:0] checksum;
   logic [ADDR_W-1:0] mem_adr;
   logic              mem_read;
   logic              mem_write;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      input  start, src_adr, dst_adr, len, mem_rdata,
      output busy, done, checksum, mem_adr, mem_read, mem_write, mem_wdata
   );

   modport slave (
      output start, src_adr, dst_adr, len, mem_rdata,
      input  busy, done, checksum, mem_adr, mem_read, mem_write, mem_wdata
   );
endinterface

// File: rtl/mem_copy_engine.sv
// Block-copy bus initiator: copies len words src->dst one word per READ/WRITE
// pair, ascending, and accumulates a 16-bit additive checksum of the words.
module mem_copy_engine #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 16,
   parameter int LEN_W  = 11
) (
   input  logic         clk,
   input  logic         rst_n,
   mem_copy_if.master   bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [LEN_W-1:0]  idx_q, idx_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [ADDR_W-1:0] src_q, src_d;
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic [DATA_W-1:0] buf_q, buf_d;
   logic [DATA_W-1:0] csum_q, csum_d;

   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] adr_q, adr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   // Next-state, datapath and registered-output decode
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      len_d   = len_q;
      src_d   = src_q;
      dst_d   = dst_q;
      buf_d   = buf_q;
      csum_d  = csum_q;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               src_d   = bus.src_adr;
               dst_d   = bus.dst_adr;
               len_d   = bus.len;
               idx_d   = {LEN_W{1'b0}};
               csum_d  = {DATA_W{1'b0}};
               state_d = (bus.len != {LEN_W{1'b0}}) ? S_READ : S_DONE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_READ: begin
            buf_d   = bus.mem_rdata;
            csum_d  = csum_q + bus.mem_rdata;
            state_d = S_WRITE;
         end
         S_WRITE: begin
            idx_d = idx_q + LEN_W'(1);
            if ((idx_q + LEN_W'(1)) == len_q) begin
               state_d = S_DONE;
            end else begin
               state_d = S_READ;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Bus outputs are registered, so they are decoded from the upcoming state
      busy_d  = 1'b0;
      done_d  = 1'b0;
      rd_d    = 1'b0;
      wr_d    = 1'b0;
      adr_d   = {ADDR_W{1'b0}};
      wdata_d = {DATA_W{1'b0}};
      case (state_d)
         S_READ: begin
            busy_d = 1'b1;
            rd_d   = 1'b1;
            adr_d  = src_d + ADDR_W'(idx_d);
         end
         S_WRITE: begin
            busy_d  = 1'b1;
            wr_d    = 1'b1;
            adr_d   = dst_d + ADDR_W'(idx_d);
            wdata_d = buf_d;
         end
         S_DONE: begin
            done_d = 1'b1;
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

   // State, datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= {LEN_W{1'b0}};
         len_q   <= {LEN_W{1'b0}};
         src_q   <= {ADDR_W{1'b0}};
         dst_q   <= {ADDR_W{1'b0}};
         buf_q   <= {DATA_W{1'b0}};
         csum_q  <= {DATA_W{1'b0}};
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         adr_q   <= {ADDR_W{1'b0}};
         wdata_q <= {DATA_W{1'b0}};
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         buf_q   <= buf_d;
         csum_q  <= csum_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         adr_q   <= adr_d;
         wdata_q <= wdata_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.checksum  = csum_q;
   assign bus.mem_adr   = adr_q;
   assign bus.mem_read  = rd_q;
   assign bus.mem_write = wr_q;
   assign bus.mem_wdata = wdata_q;

endmodule
